// File: rtl/int8_vecmac_pkg.sv
// Shared types and constants for the INT8 vector MAC and its job controller.
package int8_vecmac_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int MAC_LAT   = 8;
   localparam int MAC_OW    = 19;
   localparam int ACC_W_DEF = 27;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/mul8x8x8_wallace.sv
// 8-lane unsigned INT8 dot-product MAC: product row, 3-level reduction tree,
// then a delay line so out_valid appears MAC_LAT cycles after the input edge.
module mul8x8x8_wallace
   import int8_vecmac_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [63:0]       a,
   input  logic [63:0]       b,
   output logic              out_valid,
   output logic [MAC_OW-1:0] out_sum
);

   localparam int DL = MAC_LAT - 4;

   logic [MAC_LAT:0]    r_v;
   logic [63:0]         r_a;
   logic [63:0]         r_b;
   logic [15:0]         r_pp [8];
   logic [16:0]         r_s2 [4];
   logic [17:0]         r_s3 [2];
   logic [MAC_OW-1:0]   r_s4;
   logic [MAC_OW-1:0]   r_dl [DL];

   // Only the valid chain is reset; data is qualified by it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v <= '0;
      end else begin
         r_v <= {r_v[MAC_LAT-1:0], in_valid};
      end
   end

   always_ff @(posedge clk) begin
      r_a <= a;
      r_b <= b;
      for (int i = 0; i < 8; i++) begin
         r_pp[i] <= 16'(r_a[8*i +: 8]) * 16'(r_b[8*i +: 8]);
      end
      for (int i = 0; i < 4; i++) begin
         r_s2[i] <= {1'b0, r_pp[2*i]} + {1'b0, r_pp[2*i+1]};
      end
      for (int i = 0; i < 2; i++) begin
         r_s3[i] <= {1'b0, r_s2[2*i]} + {1'b0, r_s2[2*i+1]};
      end
      r_s4 <= {1'b0, r_s3[0]} + {1'b0, r_s3[1]};
      r_dl[0] <= r_s4;
      for (int i = 1; i < DL; i++) begin
         r_dl[i] <= r_dl[i-1];
      end
   end

   assign out_valid = r_v[MAC_LAT];
   assign out_sum   = r_dl[DL-1];

endmodule

// File: rtl/int8_dot_ctrl.sv
// Job controller for the INT8 dot-product MAC: streams chunks, accumulates results.
// Optional cycle counter output enabled by INT8_DOT_CTRL_PERF_EN.
module int8_dot_ctrl
   import int8_vecmac_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [63:0]      op_a,
   input  logic [63:0]      op_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_sum,
   output logic             busy
`ifdef INT8_DOT_CTRL_PERF_EN
   ,
   output logic [15:0]      perf_cycles
`endif
);

   localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

   state_t             r_state;
   state_t             w_next;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W:0]     r_issued;
   logic [LEN_W:0]     r_retired;
   logic [ACC_W-1:0]   r_acc;
   logic               w_cmd_hs;
   logic               w_op_hs;
   logic               w_ret;
   logic               w_mac_v;
   logic [MAC_OW-1:0]  w_mac_sum;
   logic               w_mac_rst_n;

   assign w_cmd_hs    = cmd_valid & (r_state == S_IDLE);
   assign w_op_hs     = op_valid & (r_state == S_ISSUE);
   assign w_ret       = w_mac_v &
                        ((r_state == S_ISSUE) | (r_state == S_DRAIN));
   assign w_mac_rst_n = ~rst;

   mul8x8x8_wallace u_mac (
      .clk       (clk),
      .rst_n     (w_mac_rst_n),
      .in_valid  (w_op_hs),
      .a         (op_a),
      .b         (op_b),
      .out_valid (w_mac_v),
      .out_sum   (w_mac_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      op_ready  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            op_ready = 1'b1;
            if (op_valid && r_issued == {1'b0, r_len}) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_ret && r_retired == {1'b0, r_len}) w_next = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len     <= '0;
         r_issued  <= '0;
         r_retired <= '0;
         r_acc     <= '0;
      end else if (w_cmd_hs) begin
         r_len     <= cmd_len;
         r_issued  <= '0;
         r_retired <= '0;
         r_acc     <= '0;
      end else begin
         if (w_op_hs) r_issued <= r_issued + CNT_ONE;
         if (w_ret) begin
            r_acc     <= r_acc + ACC_W'(w_mac_sum);
            r_retired <= r_retired + CNT_ONE;
         end
      end
   end

   assign res_sum = r_acc;

`ifdef INT8_DOT_CTRL_PERF_EN
   logic [15:0] r_perf_cnt;

   // Count includes the cycle in which DONE is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_cnt  <= '0;
         perf_cycles <= '0;
      end else begin
         if (w_cmd_hs) r_perf_cnt <= '0;
         else if (r_state == S_ISSUE || r_state == S_DRAIN)
            r_perf_cnt <= sat_inc16(r_perf_cnt);
         if (r_state == S_DRAIN && w_next == S_DONE)
            perf_cycles <= sat_inc16(r_perf_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_int8_dot_ctrl.sv
// Directed self-checking bench for int8_dot_ctrl.
module tb_int8_dot_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_len;
   logic        op_valid;
   logic        op_ready;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        res_valid;
   logic        res_ready;
   logic [26:0] res_sum;
   logic        busy;
`ifdef INT8_DOT_CTRL_PERF_EN
   logic [15:0] perf_cycles;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   int8_dot_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .busy      (busy)
`ifdef INT8_DOT_CTRL_PERF_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] len);
      int t = 0;
      cmd_valid = 1'b1;
      cmd_len   = len;
      while (!cmd_ready && t < 50) begin
         tick();
         t++;
      end
      if (!cmd_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic feed(input logic [63:0] a, input logic [63:0] b);
      int t = 0;
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      while (!op_ready && t < 50) begin
         tick();
         t++;
      end
      if (!op_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL op_accept: op_ready=%0b required 1", op_ready);
      end
      tick();
      op_valid = 1'b0;
   endtask

   task automatic wait_res(output int cyc);
      cyc = 0;
      while (!res_valid && cyc < 600) begin
         tick();
         cyc++;
      end
   endtask

   task automatic take_res();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_vec++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready);
      end
      n_vec++;
      if (op_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_op_ready: got %0b want 0", op_ready);
      end
      n_vec++;
      if (res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_res_valid: got %0b want 0", res_valid);
      end
      n_vec++;
      if (res_sum !== 27'd0) begin
         n_err++;
         $display("FAIL rst_res_sum: got %0d want 0", res_sum);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_busy: got %0b want 0", busy);
      end
   endtask

   task automatic test_single();
      int cyc;
      send_cmd(8'd0);
      feed({8{8'hFF}}, {8{8'hFF}});
      wait_res(cyc);
      n_vec++;
      if (cyc !== 9) begin
         n_err++;
         $display("FAIL single_latency: got %0d want 9", cyc);
      end
      n_vec++;
      if (res_sum !== 27'd520200) begin
         n_err++;
         $display("FAIL single_sum: got %0d want 520200", res_sum);
      end
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL single_busy: got %0b want 1", busy);
      end
`ifdef INT8_DOT_CTRL_PERF_EN
      n_vec++;
      if (perf_cycles !== 16'd10) begin
         n_err++;
         $display("FAIL perf_cycles: got %0d want 10", perf_cycles);
      end
`endif
      take_res();
      n_vec++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_release: res_valid=%0b cmd_ready=%0b want 0/1",
                  res_valid, cmd_ready);
      end
   endtask

   task automatic test_full();
      int cyc;
      send_cmd(8'd255);
      for (int i = 0; i < 256; i++) feed({8{8'hFF}}, {8{8'hFF}});
      n_vec++;
      if (op_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_op_ready_drain: got %0b want 0", op_ready);
      end
      wait_res(cyc);
      n_vec++;
      if (res_sum !== 27'd133171200 || res_valid !== 1'b1) begin
         n_err++;
         $display("FAIL full_sum: got %0d valid %0b want 133171200 valid 1",
                  res_sum, res_valid);
      end
      take_res();
   endtask

   task automatic test_gaps();
      int cyc;
      send_cmd(8'd3);
      for (int i = 0; i < 4; i++) begin
         feed(64'h0706050403020100, 64'h0101010101010101);
         if (i < 3) begin
            tick();
            n_vec++;
            if (op_ready !== 1'b1) begin
               n_err++;
               $display("FAIL gap_op_ready: got %0b want 1", op_ready);
            end
         end
      end
      wait_res(cyc);
      n_vec++;
      if (cyc !== 9) begin
         n_err++;
         $display("FAIL gap_latency: got %0d want 9", cyc);
      end
      n_vec++;
      if (res_sum !== 27'd112) begin
         n_err++;
         $display("FAIL gap_sum: got %0d want 112", res_sum);
      end
      take_res();
   endtask

   task automatic test_back_to_back();
      int cyc;
      send_cmd(8'd0);
      feed({8{8'h10}}, {8{8'h03}});
      wait_res(cyc);
      cmd_valid = 1'b1;
      cmd_len   = 8'd1;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (res_valid !== 1'b1 || res_sum !== 27'd384 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_%0d: valid=%0b sum=%0d cmd_ready=%0b want 1/384/0",
                     i, res_valid, res_sum, cmd_ready);
         end
         tick();
      end
      take_res();
      n_vec++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle: cmd_ready=%0b busy=%0b want 1/0", cmd_ready, busy);
      end
      send_cmd(8'd1);
      feed(64'h0807060504030201, {8{8'h02}});
      feed(64'h0807060504030201, {8{8'h02}});
      wait_res(cyc);
      n_vec++;
      if (res_sum !== 27'd144 || res_valid !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_sum: got %0d valid %0b want 144 valid 1", res_sum, res_valid);
      end
      take_res();
   endtask

   task automatic test_mid_reset();
      int cyc;
      send_cmd(8'd7);
      for (int i = 0; i < 8; i++) feed({8{8'hFF}}, {8{8'hFF}});
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 ||
          res_sum !== 27'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_outputs: cr=%0b or=%0b rv=%0b sum=%0d busy=%0b want 1/0/0/0/0",
                  cmd_ready, op_ready, res_valid, res_sum, busy);
      end
      send_cmd(8'd0);
      feed({8{8'h02}}, {8{8'h02}});
      wait_res(cyc);
      n_vec++;
      if (cyc !== 9) begin
         n_err++;
         $display("FAIL midrst_latency: got %0d want 9", cyc);
      end
      n_vec++;
      if (res_sum !== 27'd32) begin
         n_err++;
         $display("FAIL midrst_sum: got %0d want 32", res_sum);
      end
      take_res();
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;
      test_reset();
      test_single();
      test_full();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/int8_dot_ctrl.md
INT8_DOT_CTRL -- requirements
Module: int8_dot_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of cmd_len; a job is cmd_len+1 chunks, so 1..256 chunks.
REQ-002 SHALL have parameter ACC_W, default 27: result width; 256 x 520200 = 133171200 < 2^27.
REQ-003 SHALL have port clk  in  1: single clock, rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1: job request.
REQ-006 SHALL have port cmd_ready  out  1: job accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_len  in  LEN_W: chunk count minus 1.
REQ-008 SHALL have ports op_valid  in  1 and op_ready  out  1: operand chunk handshake.
REQ-009 SHALL have ports op_a  in  64 and op_b  in  64: 8 x unsigned INT8 per operand, lane0 = bits [7:0].
REQ-010 SHALL have ports res_valid  out  1 and res_ready  in  1: result handshake.
REQ-011 SHALL have port res_sum  out  ACC_W: dot-product result.
REQ-012 SHALL have port busy  out  1: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement the FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE, with IDLE as the reset state.
REQ-014 IDLE SHALL drive cmd_ready=1; on cmd handshake it SHALL latch cmd_len, clear the accumulator and the issue/retire counters, and go to ISSUE.
REQ-015 ISSUE SHALL drive op_ready=1; each op handshake SHALL present op_a/op_b to the MAC with in_valid=1 in that cycle and increment the issue count.
REQ-016 A cycle without an op handshake SHALL drive MAC in_valid=0; gaps of any length SHALL be legal.
REQ-017 On the handshake that brings the issue count to cmd_len+1, the FSM SHALL go to DRAIN; op_ready SHALL be 0 outside ISSUE.
REQ-018 Each MAC out_valid cycle SHALL add the zero-extended 19-bit out_sum to the accumulator and increment the retire count; the accumulator SHALL NOT wrap within the legal range.
REQ-019 The FSM SHALL leave DRAIN for DONE on the edge where the retire count reaches cmd_len+1.
REQ-020 MAC latency SHALL be 8 cycles; res_valid SHALL assert exactly 9 cycles after the edge that samples the last op handshake.
REQ-021 DONE SHALL hold res_valid=1 and res_sum stable until res_ready=1; on that handshake it SHALL go to IDLE.
REQ-022 cmd_ready SHALL be 0 in ISSUE, DRAIN and DONE; the next command SHALL be accepted no earlier than the cycle after the result handshake.
REQ-023 If ISSUE is entered with op_valid already high, the first chunk SHALL be taken in the first ISSUE cycle (no bubble).
REQ-024 MAC out_valid outside ISSUE/DRAIN SHALL be ignored (it cannot occur in legal operation).

Reset
REQ-025 While rst=1, on each clock edge the block SHALL force: state=IDLE, cmd_ready=1 (from the first cycle after reset), op_ready=0, res_valid=0, res_sum=0, busy=0, accumulator and counters cleared.
REQ-026 The MAC reset (rst_n) SHALL be driven by ~rst, so that products in flight at a mid-job reset are discarded and never accumulated after reset release.

Configuration
REQ-027 With INT8_DOT_CTRL_PERF_EN defined, the block SHALL add output perf_cycles (16 bit): cycles from cmd accept to res_valid assertion, saturating at 0xFFFF, updated when res_valid rises, and reset to 0.
REQ-028 Without INT8_DOT_CTRL_PERF_EN, perf_cycles and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-029 The shared package int8_vecmac_pkg SHALL hold the FSM state encoding, MAC_LAT=8, the MAC output width 19, and the ACC_W default.
REQ-030 The block SHALL contain exactly one sub-module: one instance of the 8-lane INT8 Wallace MAC (mul8x8x8_wallace); the counters and the accumulator stay inline.

Verification
REQ-031 cmd_len=0, one chunk with all lanes a=b=0xFF -> res_sum=520200, res_valid 9 cycles after the op handshake.
REQ-032 cmd_len=255, all chunks 0xFF/0xFF -> res_sum=133171200, no overflow.
REQ-033 cmd_len=3, lanes a=k, b=1 (k = lane index), op_valid toggling every other cycle -> res_sum=4 x 28=112; gaps handled correctly.
REQ-034 res_ready held low 5 cycles after res_valid -> res_sum stable; cmd_valid high during that time is not accepted; the second job then accepted, with its result independent of the first.
REQ-035 rst pulsed for 1 cycle in DRAIN of a cmd_len=7 job -> outputs at reset values; a following cmd_len=0 job with a=b=0x02 per lane -> res_sum=32, no stale products.
REQ-036 With INT8_DOT_CTRL_PERF_EN, a cmd_len=0 job fed with no gap -> perf_cycles=10.
